// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring DIV/IDIV engine for 8/16/32-bit operands.
// Produces one quotient bit per clock and flags #DE on zero divisor or quotient overflow.
module div_unit #(
    parameter int unsigned EARLY_DE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic        isize,
    input  logic        opsize,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_error,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  sz_q, sz_d;
    logic [63:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] absdvs_q, absdvs_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] remo_q, remo_d;

    // Size-dependent decode
    logic [5:0]  n;
    logic [31:0] mask_n;
    logic [63:0] mask_2n;
    logic        sd, sv, qmsb;

    // PREP datapath
    logic [63:0] dvd_m, abs_dvd;
    logic [31:0] dvs_m, abs_dvs, hi, lo;
    logic        zero, ovf;

    // CALC datapath
    logic [32:0] rem_sh, rem_sub;
    logic        ge;

    // FIX datapath
    logic [31:0] q_fix, r_fix, half;
    logic        range_err, fix_err;

    logic accept;

    always_comb begin
        unique case (sz_q)
            2'd0: begin
                n = 6'd8; mask_n = 32'h0000_00FF; mask_2n = 64'h0000_0000_0000_FFFF;
                sd = dvd_q[15]; sv = dvs_q[7]; qmsb = quo_q[7];
            end
            2'd1: begin
                n = 6'd16; mask_n = 32'h0000_FFFF; mask_2n = 64'h0000_0000_FFFF_FFFF;
                sd = dvd_q[31]; sv = dvs_q[15]; qmsb = quo_q[15];
            end
            default: begin
                n = 6'd32; mask_n = 32'hFFFF_FFFF; mask_2n = 64'hFFFF_FFFF_FFFF_FFFF;
                sd = dvd_q[63]; sv = dvs_q[31]; qmsb = quo_q[31];
            end
        endcase
        sd = sd & sgn_q;
        sv = sv & sgn_q;

        dvd_m   = dvd_q & mask_2n;
        abs_dvd = sd ? ((~dvd_m + 64'd1) & mask_2n) : dvd_m;
        dvs_m   = dvs_q & mask_n;
        abs_dvs = sv ? ((~dvs_m + 32'd1) & mask_n) : dvs_m;
        hi      = 32'(abs_dvd >> n);
        lo      = abs_dvd[31:0] & mask_n;
        zero    = (dvs_m == 32'd0);
        // Unsigned quotient cannot fit in N bits when the high half already reaches the divisor
        ovf     = (hi >= abs_dvs);

        rem_sh  = {rem_q, qmsb};
        ge      = (rem_sh >= {1'b0, absdvs_q});
        rem_sub = ge ? (rem_sh - {1'b0, absdvs_q}) : rem_sh;

        q_fix     = qneg_q ? ((~quo_q + 32'd1) & mask_n) : (quo_q & mask_n);
        r_fix     = rneg_q ? ((~rem_q + 32'd1) & mask_n) : (rem_q & mask_n);
        half      = 32'd1 << (n - 6'd1);
        range_err = sgn_q & (qneg_q ? (quo_q > half) : (quo_q >= half));
        fix_err   = zero_q | ovf_q | range_err;
    end

    assign accept = start & ((state_q == StIdle) | (state_q == StDone));

    always_comb begin
        state_d  = state_q;
        sgn_d    = sgn_q;
        sz_d     = sz_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        absdvs_d = absdvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        quot_d   = quot_q;
        remo_d   = remo_q;

        if (accept) begin
            sgn_d = signed_op;
            sz_d  = isize ? (opsize ? 2'd2 : 2'd1) : 2'd0;
            dvd_d = dividend;
            dvs_d = divisor;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StPrep;
            end
            StPrep: begin
                absdvs_d = abs_dvs;
                rem_d    = hi;
                quo_d    = lo;
                cnt_d    = n;
                qneg_d   = sd ^ sv;
                rneg_d   = sd;
                zero_d   = zero;
                ovf_d    = ovf;
                // Early #DE exits through FIX so every result is committed in one place
                if ((EARLY_DE != 0) && (zero || ovf)) state_d = StFix;
                else                                  state_d = StCalc;
            end
            StCalc: begin
                rem_d = rem_sub[31:0];
                quo_d = ((quo_q << 1) | {31'd0, ge}) & mask_n;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = StFix;
            end
            StFix: begin
                err_d = fix_err;
                if (!fix_err) begin
                    quot_d = q_fix;
                    remo_d = r_fix;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = accept ? StPrep : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            sgn_q    <= 1'b0;
            sz_q     <= 2'd0;
            dvd_q    <= 64'd0;
            dvs_q    <= 32'd0;
            absdvs_q <= 32'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            cnt_q    <= 6'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            quot_q   <= 32'd0;
            remo_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            sgn_q    <= sgn_d;
            sz_q     <= sz_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            absdvs_q <= absdvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            quot_q   <= quot_d;
            remo_q   <= remo_d;
        end
    end

    assign busy      = (state_q == StPrep) | (state_q == StCalc) | (state_q == StFix);
    assign done      = (state_q == StDone);
    assign div_error = done & err_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, #DE, busy/done handshake and reset abort.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic        isize;
    logic        opsize;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_error;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int errors = 0;

    div_unit #(.EARLY_DE(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .isize     (isize),
        .opsize    (opsize),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_error (div_error),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clock = ~clock;

    // Issues one operation and returns clocks from the start edge to done (-1 on timeout).
    // With noise set, a bogus start is pulsed while the engine is busy.
    task automatic run_op(input logic sgn, input logic isz, input logic osz,
                          input logic [63:0] dvd, input logic [31:0] dvs,
                          input bit noise, output int lat);
        @(negedge clock);
        start = 1'b1; signed_op = sgn; isize = isz; opsize = osz;
        dividend = dvd; divisor = dvs;
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (noise && k == 3) begin
                start = 1'b1; signed_op = 1'b0; isize = 1'b0;
                dividend = 64'h00FF; divisor = 32'h1;
            end
            if (noise && k == 4) start = 1'b0;
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_with_done: got %b want 0", busy);
        end
    endtask

    task automatic test_reset;
        start = 1'b0; signed_op = 1'b0; isize = 1'b0; opsize = 1'b0;
        dividend = 64'd0; divisor = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, div_error} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b q=%h r=%h want all zero",
                     busy, done, div_error, quotient, remainder);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_div8;
        int lat;
        run_op(1'b0, 1'b0, 1'b0, 64'h0064, 32'h07, 1'b0, lat);
        checks++;
        if (lat !== 10 || div_error !== 1'b0 || quotient !== 32'h0E || remainder !== 32'h02) begin
            errors++;
            $display("FAIL div8: got lat=%0d err=%b q=%h r=%h want 10 0 0000000e 00000002",
                     lat, div_error, quotient, remainder);
        end
    endtask

    task automatic test_idiv16;
        int lat;
        run_op(1'b1, 1'b1, 1'b0, 64'hFFFF_FF9C, 32'h0007, 1'b0, lat);
        checks++;
        if (lat !== 18 || div_error !== 1'b0 || quotient !== 32'hFFF2 || remainder !== 32'hFFFE) begin
            errors++;
            $display("FAIL idiv16: got lat=%0d err=%b q=%h r=%h want 18 0 0000fff2 0000fffe",
                     lat, div_error, quotient, remainder);
        end
    endtask

    task automatic test_div32;
        int lat;
        run_op(1'b0, 1'b1, 1'b1, 64'h0000_0001_0000_0000, 32'h10, 1'b0, lat);
        checks++;
        if (lat !== 34 || div_error !== 1'b0 || quotient !== 32'h1000_0000 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL div32: got lat=%0d err=%b q=%h r=%h want 34 0 10000000 00000000",
                     lat, div_error, quotient, remainder);
        end
    endtask

    task automatic test_div_error;
        int lat;
        // Prior results (0x10000000 / 0) must survive every #DE below
        run_op(1'b0, 1'b1, 1'b0, 64'h1234, 32'h0, 1'b0, lat);
        checks++;
        if (lat !== 2 || div_error !== 1'b1 || quotient !== 32'h1000_0000 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL div16_by_zero: got lat=%0d err=%b q=%h r=%h want 2 1 10000000 00000000",
                     lat, div_error, quotient, remainder);
        end
        @(posedge clock);
        #1;
        checks++;
        if (div_error !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_after_done: got err=%b done=%b want 0 0", div_error, done);
        end
        run_op(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 1'b0, lat);
        checks++;
        if (lat !== 2 || div_error !== 1'b1 || quotient !== 32'h1000_0000) begin
            errors++;
            $display("FAIL idiv32_by_zero: got lat=%0d err=%b q=%h want 2 1 10000000",
                     lat, div_error, quotient);
        end
        run_op(1'b0, 1'b0, 1'b0, 64'h0400, 32'h02, 1'b0, lat);
        checks++;
        if (lat !== 2 || div_error !== 1'b1 || quotient !== 32'h1000_0000 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL div8_overflow: got lat=%0d err=%b q=%h r=%h want 2 1 10000000 00000000",
                     lat, div_error, quotient, remainder);
        end
    endtask

    task automatic test_idiv8_range;
        int lat;
        run_op(1'b1, 1'b0, 1'b0, 64'hFF80, 32'h01, 1'b0, lat);
        checks++;
        if (lat !== 10 || div_error !== 1'b0 || quotient !== 32'h80 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL idiv8_min: got lat=%0d err=%b q=%h r=%h want 10 0 00000080 00000000",
                     lat, div_error, quotient, remainder);
        end
        run_op(1'b1, 1'b0, 1'b0, 64'h0080, 32'h01, 1'b0, lat);
        checks++;
        if (lat !== 10 || div_error !== 1'b1 || quotient !== 32'h80) begin
            errors++;
            $display("FAIL idiv8_range: got lat=%0d err=%b q=%h want 10 1 00000080",
                     lat, div_error, quotient);
        end
        run_op(1'b1, 1'b0, 1'b0, 64'h0064, 32'hF9, 1'b0, lat);
        checks++;
        if (lat !== 10 || div_error !== 1'b0 || quotient !== 32'hF2 || remainder !== 32'h02) begin
            errors++;
            $display("FAIL idiv8_negdivisor: got lat=%0d err=%b q=%h r=%h want 10 0 000000f2 00000002",
                     lat, div_error, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(1'b0, 1'b0, 1'b0, 64'h0064, 32'h07, 1'b1, lat);
        checks++;
        if (lat !== 10 || quotient !== 32'h0E || remainder !== 32'h02) begin
            errors++;
            $display("FAIL ignore_busy_start: got lat=%0d q=%h r=%h want 10 0000000e 00000002",
                     lat, quotient, remainder);
        end
        // Next start lands in the done cycle
        run_op(1'b0, 1'b0, 1'b0, 64'h00FF, 32'h10, 1'b0, lat);
        checks++;
        if (lat !== 10 || div_error !== 1'b0 || quotient !== 32'h0F || remainder !== 32'h0F) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d err=%b q=%h r=%h want 10 0 0000000f 0000000f",
                     lat, div_error, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_calc;
        int lat;
        bit stray;
        @(negedge clock);
        start = 1'b1; signed_op = 1'b0; isize = 1'b1; opsize = 1'b1;
        dividend = 64'h0000_0001_0000_0000; divisor = 32'h10;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b done=%b q=%h want 0 0 00000000",
                     busy, done, quotient);
        end
        @(negedge clock);
        reset = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL reset_stray_done: got activity after reset want idle");
        end
        run_op(1'b0, 1'b0, 1'b0, 64'h0064, 32'h07, 1'b0, lat);
        checks++;
        if (lat !== 10 || quotient !== 32'h0E || remainder !== 32'h02) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d q=%h r=%h want 10 0000000e 00000002",
                     lat, quotient, remainder);
        end
    endtask

    initial begin
        test_reset();
        test_div8();
        test_idiv16();
        test_div32();
        test_div_error();
        test_idiv8_range();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
